// File: rtl/text_line_reader_pkg.sv
// Shared console / text-RAM definitions: geometry, character word layout,
// reader state encoding and the text-RAM request/result port types.
// Compile first; the macros below default the geometry unless set externally.
`ifndef CONSOLE_COLUMNS
`define CONSOLE_COLUMNS 16
`endif
`ifndef CONSOLE_LINES
`define CONSOLE_LINES 8
`endif
`ifndef TEXT_RAM_CHAR_WIDTH
`define TEXT_RAM_CHAR_WIDTH 32
`endif

package text_line_reader_pkg;

    localparam int CONSOLE_COLUMNS = `CONSOLE_COLUMNS;
    localparam int CONSOLE_LINES   = `CONSOLE_LINES;
    localparam int CHAR_W          = `TEXT_RAM_CHAR_WIDTH;
    localparam int ROW_W           = 8;

    // Character word: [7:0] code, [19:8] foreground, [31:20] background.
    localparam int ATTR_W = 12;
    localparam int FG_LSB = 8;
    localparam int BG_LSB = 20;

    // Space character, grey-on-black.
    localparam logic [CHAR_W-1:0] BLANK_CHAR = CHAR_W'(32'h0007fc20);

    typedef enum logic [2:0] {
        IDLE,
        READ0,
        READ1,
        LATCH,
        STREAM
    } reader_state_t;

    typedef struct packed {
        logic [ROW_W-1:0] address;
        logic             wren;
    } TextRamRequest_t;

    // One full text line per RAM word; slot i is column i.
    typedef struct packed {
        logic [CONSOLE_COLUMNS-1:0][CHAR_W-1:0] data;
    } TextRamResult_t;

endpackage

// File: rtl/text_line_reader_cursor.sv
// Cursor overlay: swaps foreground/background attribute fields of one character.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Ports: i_hit selects the swap, i_char in, o_char out; code byte passes unchanged.
module text_cursor_overlay
    import text_line_reader_pkg::*;
(
    input  logic              i_hit,
    input  logic [CHAR_W-1:0] i_char,
    output logic [CHAR_W-1:0] o_char
);

    always_comb begin
        o_char = i_char;
        if (i_hit) begin
            o_char[FG_LSB +: ATTR_W] = i_char[BG_LSB +: ATTR_W];
            o_char[BG_LSB +: ATTR_W] = i_char[FG_LSB +: ATTR_W];
        end
    end

endmodule

// File: rtl/text_line_reader.sv
// Text line reader: fetches one line from text RAM and streams it column by column.
// Latency: handshake to first char_valid 4 edges (in-range row) / 2 edges (row >= ROWS, BLANK fill).
// Backpressure: char_data/char_col hold while char_ready is low; fetch_ready is high only in IDLE.
// Ports: fetch_valid/fetch_row/fetch_ready request a line; ramReq/ramRes read the text RAM
// (2-cycle read latency, never writes); char_valid/char_ready/char_data/char_col stream the
// characters; line_done pulses once after the last column; cursor_row/cursor_col are used only
// when TEXT_READER_CURSOR_EN is defined (cursor cell emitted with swapped attributes).
module text_line_reader
    import text_line_reader_pkg::*;
#(
    parameter int                COLS  = `CONSOLE_COLUMNS,
    parameter int                ROWS  = `CONSOLE_LINES,
    parameter logic [CHAR_W-1:0] BLANK = BLANK_CHAR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [7:0]        fetch_row,
    output logic              fetch_ready,
    output TextRamRequest_t   ramReq,
    input  TextRamResult_t    ramRes,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [CHAR_W-1:0] char_data,
    output logic [7:0]        char_col,
    output logic              line_done,
    input  logic [7:0]        cursor_row,
    input  logic [7:0]        cursor_col
);

    localparam logic [8:0] ROWS_LIM = 9'(ROWS);
    localparam logic [7:0] LAST_COL = 8'(COLS - 1);

    reader_state_t     r_state;
    logic [7:0]        r_row;
    logic [7:0]        r_col;
    logic [7:0]        r_addr;
    logic              r_char_valid;
    logic              r_line_done;
    logic              r_fetch_ready;
    logic [CHAR_W-1:0] r_line [COLS];

    logic              w_row_oob;
    logic [CHAR_W-1:0] w_slot;

    assign w_row_oob = ({1'b0, r_row} >= ROWS_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_addr        <= '0;
            r_char_valid  <= 1'b0;
            r_line_done   <= 1'b0;
            r_fetch_ready <= 1'b1;
        end else begin
            r_line_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (fetch_valid && r_fetch_ready) begin
                        r_row         <= fetch_row;
                        r_fetch_ready <= 1'b0;
                        r_state       <= READ0;
                        // Out-of-range rows never touch the RAM address.
                        if ({1'b0, fetch_row} < ROWS_LIM)
                            r_addr <= fetch_row;
                    end
                end
                READ0: begin
                    if (w_row_oob) begin
                        r_state      <= STREAM;
                        r_col        <= '0;
                        r_char_valid <= 1'b1;
                    end else begin
                        r_state <= READ1;
                    end
                end
                READ1: r_state <= LATCH;
                LATCH: begin
                    r_state      <= STREAM;
                    r_col        <= '0;
                    r_char_valid <= 1'b1;
                end
                STREAM: begin
                    if (char_ready) begin
                        if (r_col == LAST_COL) begin
                            r_char_valid  <= 1'b0;
                            r_line_done   <= 1'b1;
                            r_fetch_ready <= 1'b1;
                            r_col         <= '0;
                            r_state       <= IDLE;
                        end else begin
                            r_col <= r_col + 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line snapshot: contents are only ever read after a LATCH or BLANK fill,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (r_state == LATCH) begin
            for (int i = 0; i < COLS; i++)
                r_line[i] <= ramRes.data[i];
        end else if (r_state == READ0 && w_row_oob) begin
            for (int i = 0; i < COLS; i++)
                r_line[i] <= BLANK;
        end
    end

    always_comb begin
        w_slot = r_line[0];
        for (int i = 0; i < COLS; i++)
            if (r_col == 8'(i))
                w_slot = r_line[i];
    end

    assign ramReq      = '{address: r_addr, wren: 1'b0};
    assign fetch_ready = r_fetch_ready;
    assign char_valid  = r_char_valid;
    assign char_col    = r_col;
    assign line_done   = r_line_done;

`ifdef TEXT_READER_CURSOR_EN
    logic w_cursor_hit;
    assign w_cursor_hit = (r_row == cursor_row) && (r_col == cursor_col);

    text_cursor_overlay u_cursor (
        .i_hit  (w_cursor_hit),
        .i_char (w_slot),
        .o_char (char_data)
    );
`else
    logic w_unused_cursor;
    assign w_unused_cursor = ^{cursor_row, cursor_col};
    assign char_data       = w_slot;
`endif

endmodule

// File: tb/tb_text_line_reader.sv
`timescale 1ns/1ps
module tb_text_line_reader;
    import text_line_reader_pkg::*;

    localparam int COLS = CONSOLE_COLUMNS;
    localparam int ROWS = CONSOLE_LINES;
    localparam logic [31:0] BLANK_W = 32'h0007fc20;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  col;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            fetch_valid;
    logic [7:0]      fetch_row;
    logic            fetch_ready;
    TextRamRequest_t ramReq;
    TextRamResult_t  ramRes;
    TextRamResult_t  stage1;
    logic            char_valid;
    logic            char_ready;
    logic [31:0]     char_data;
    logic [7:0]      char_col;
    logic            line_done;
    logic [7:0]      cursor_row;
    logic [7:0]      cursor_col;

    logic [31:0] mem [256][COLS];
    exp_t        exp_q [$];
    logic [7:0]  exp_addr;
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    text_line_reader dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_row   (fetch_row),
        .fetch_ready (fetch_ready),
        .ramReq      (ramReq),
        .ramRes      (ramRes),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .char_data   (char_data),
        .char_col    (char_col),
        .line_done   (line_done),
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col)
    );

    // Text RAM with 2-cycle read latency.
    always @(posedge clk) begin
        for (int c = 0; c < COLS; c++)
            stage1.data[c] <= mem[ramReq.address][c];
        ramRes <= stage1;
    end

    // Row 3 col 0 -> 32'h8030f041 ('A'), row 3 col 5 -> 32'h8030f546 ('F').
    function automatic logic [31:0] ram_word(input int r, input int c, input bit alt);
        logic [7:0] base;
        base = alt ? 8'h61 : 8'h41;
        return {12'h800 | 12'(r), 12'(12'h0f0 + c), 8'(base + 8'(c))};
    endfunction

    function automatic logic [31:0] exp_char(input int r, input int c);
        logic [31:0] w;
        w = (r < ROWS) ? mem[r][c] : BLANK_W;
`ifdef TEXT_READER_CURSOR_EN
        if (r == int'(cursor_row) && c == int'(cursor_col))
            w = {w[19:8], w[31:20], w[7:0]};
`endif
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard on every transfer, checks stall stability
    // against the queue head and the line_done pulse timing.
    initial begin : monitor
        bit pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                check("wren", 64'(ramReq.wren), 64'd0);
                check("line_done", 64'(line_done), 64'(pend));
                pend = 1'b0;
                if (char_valid) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL spurious_char: col %0d data %0h with nothing expected", char_col, char_data);
                    end else begin
                        check("char_data", 64'(char_data), 64'(exp_q[0].data));
                        check("char_col", 64'(char_col), 64'(exp_q[0].col));
                        if (char_ready) begin
                            if (exp_q[0].col == 8'(COLS - 1)) pend = 1'b1;
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic run_line(input int row, input bit toggle, input bit rewrite);
        int lat;
        int vcyc;
        for (int c = 0; c < COLS; c++)
            exp_q.push_back('{data: exp_char(row, c), col: 8'(c)});
        if (row < ROWS) exp_addr = 8'(row);
        check("fetch_ready_idle", 64'(fetch_ready), 64'd1);
        fetch_valid = 1'b1;
        fetch_row   = 8'(row);
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        lat = 1;
        while (!char_valid && lat < 20) begin
            check("fetch_ready_busy", 64'(fetch_ready), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), (row < ROWS) ? 64'd4 : 64'd2);
        check("ram_addr", 64'(ramReq.address), 64'(exp_addr));
        vcyc = 0;
        while (char_valid && vcyc < 200) begin
            char_ready = toggle ? ((vcyc % 2) == 0) : 1'b1;
            if (rewrite && vcyc == 2)
                for (int c = 0; c < COLS; c++) mem[3][c] = ram_word(3, c, 1'b1);
            @(posedge clk); #1;
            vcyc++;
        end
        char_ready = 1'b1;
        check("valid_cycles", 64'(vcyc), toggle ? 64'(2 * COLS - 1) : 64'(COLS));
        check("fetch_ready_after", 64'(fetch_ready), 64'd1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("ram_addr_after", 64'(ramReq.address), 64'(exp_addr));
        @(posedge clk); #1;
    endtask

    initial begin : stimulus
        int k;
        rst = 1'b1;
        fetch_valid = 1'b0;
        fetch_row   = 8'd0;
        char_ready  = 1'b1;
        cursor_row  = 8'd3;
        cursor_col  = 8'd5;
        exp_addr    = 8'd0;
        for (int r = 0; r < 256; r++)
            for (int c = 0; c < COLS; c++)
                mem[r][c] = ram_word(r, c, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_char_valid", 64'(char_valid), 64'd0);
        check("rst_line_done", 64'(line_done), 64'd0);
        check("rst_addr", 64'(ramReq.address), 64'd0);
        check("rst_wren", 64'(ramReq.wren), 64'd0);
        check("rst_col", 64'(char_col), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("fetch_ready_after_rst", 64'(fetch_ready), 64'd1);

        // Hand-computed spot values for row 3.
        check("ref_r3c0", 64'(exp_char(3, 0)), 64'h8030f041);
`ifdef TEXT_READER_CURSOR_EN
        check("ref_r3c5", 64'(exp_char(3, 5)), 64'h0f580346);
`else
        check("ref_r3c5", 64'(exp_char(3, 5)), 64'h8030f546);
`endif

        run_line(3, 1'b0, 1'b0);          // basic line, always ready
        run_line(6, 1'b1, 1'b0);          // ready toggling 1/0
        run_line(ROWS + 5, 1'b0, 1'b0);   // out of range: BLANK, address untouched
        run_line(0, 1'b1, 1'b0);          // first row
        run_line(ROWS - 1, 1'b0, 1'b0);   // last row
        run_line(3, 1'b0, 1'b1);          // RAM rewritten mid-stream: old snapshot
        run_line(3, 1'b0, 1'b0);          // rewritten contents now visible

        // Reset in the middle of a line at column 10.
        for (int c = 0; c < COLS; c++)
            exp_q.push_back('{data: exp_char(2, c), col: 8'(c)});
        fetch_valid = 1'b1;
        fetch_row   = 8'd2;
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        k = 0;
        while (!(char_valid && char_col == 8'd10) && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("reached_col10", 64'(char_col), 64'd10);
        rst = 1'b1;
        #1;
        check("midrst_char_valid", 64'(char_valid), 64'd0);
        check("midrst_line_done", 64'(line_done), 64'd0);
        check("midrst_addr", 64'(ramReq.address), 64'd0);
        exp_q.delete();
        exp_addr = 8'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("fetch_ready_post_midrst", 64'(fetch_ready), 64'd1);
        run_line(2, 1'b0, 1'b0);          // restarts at column 0

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
